// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one ALU between two requesters.
// Evaluates ARM condition codes against an internal NZCV register and returns results.
module alu_share_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [7:0]         req_cond,
  input  logic [1:0]         req_s,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]   alu_il,
  output logic [WIDTH-1:0]   alu_ir,
  output logic [3:0]         alu_if,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_n,
  input  logic               alu_z,
  input  logic               alu_c,
  input  logic               alu_v,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_exec,
  output logic               rsp_we,
  output logic [3:0]         flags
);

  // Pointer resets to the opposite requester so FIRST_PRIO wins the first contention.
  localparam logic LastRst = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic [3:0]         op_q, op_d;
  logic [3:0]         cond_q, cond_d;
  logic               s_q, s_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_exec_q, rsp_exec_d;
  logic               rsp_we_q, rsp_we_d;
  logic [3:0]         flags_q, flags_d;

  logic               grant_id;
  logic               accept;
  logic               pass;
  logic               cmp_op;
  logic               fn, fz, fc, fv;

  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_q;
      default: grant_id = 1'b0;
    endcase
    req_ready = 2'b00;
    if (rst_n && (state_q == StIdle) && (req_valid != 2'b00)) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid & req_ready);

  assign fn = flags_q[3];
  assign fz = flags_q[2];
  assign fc = flags_q[1];
  assign fv = flags_q[0];

  always_comb begin
    pass = 1'b0;
    unique case (cond_q)
      4'h0: pass = fz;
      4'h1: pass = ~fz;
      4'h2: pass = fc;
      4'h3: pass = ~fc;
      4'h4: pass = fn;
      4'h5: pass = ~fn;
      4'h6: pass = fv;
      4'h7: pass = ~fv;
      4'h8: pass = fc & ~fz;
      4'h9: pass = ~fc | fz;
      4'hA: pass = (fn == fv);
      4'hB: pass = (fn != fv);
      4'hC: pass = ~fz & (fn == fv);
      4'hD: pass = fz | (fn != fv);
      4'hE: pass = 1'b1;
      4'hF: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  // TST/TEQ/CMP/CMN: always update flags when executed, never write back.
  assign cmp_op = (op_q[3:2] == 2'b10);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    op_d       = op_q;
    cond_d     = cond_q;
    s_d        = s_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_exec_d = rsp_exec_q;
    rsp_we_d   = rsp_we_q;
    flags_d    = flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_d  = grant_id;
          id_d    = grant_id;
          op_d    = grant_id ? req_op[7:4]   : req_op[3:0];
          cond_d  = grant_id ? req_cond[7:4] : req_cond[3:0];
          s_d     = grant_id ? req_s[1]      : req_s[0];
          a_d     = grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d     = grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_data_d = alu_out;
        rsp_exec_d = pass;
        rsp_we_d   = pass & ~cmp_op;
        if (pass && (s_q || cmp_op)) begin
          flags_d = {alu_n, alu_z, alu_c, alu_v};
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= LastRst;
      id_q       <= 1'b0;
      op_q       <= '0;
      cond_q     <= '0;
      s_q        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_exec_q <= 1'b0;
      rsp_we_q   <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      op_q       <= op_d;
      cond_q     <= cond_d;
      s_q        <= s_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_exec_q <= rsp_exec_d;
      rsp_we_q   <= rsp_we_d;
      flags_q    <= flags_d;
    end
  end

  assign alu_il    = a_q;
  assign alu_ir    = b_q;
  assign alu_if    = op_q;
  assign alu_cin   = flags_q[1];
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_exec  = rsp_exec_q;
  assign rsp_we    = rsp_we_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ARM-style ALU model, directed vector table, randomized ops
// against a transaction-level reference, and arbitration / backpressure / reset sequences.
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [7:0]  req_cond;
  logic [1:0]  req_s;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [31:0] alu_il;
  logic [31:0] alu_ir;
  logic [3:0]  alu_if;
  logic        alu_cin;
  logic [31:0] alu_out;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_exec;
  logic        rsp_we;
  logic [3:0]  flags;

  alu_share_ctrl #(.WIDTH(32), .FIRST_PRIO(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_cond  (req_cond),
    .req_s     (req_s),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_il    (alu_il),
    .alu_ir    (alu_ir),
    .alu_if    (alu_if),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_exec  (rsp_exec),
    .rsp_we    (rsp_we),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  cond;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic [31:0] data;
    logic        exec;
    logic        we;
    logic        id;
    logic        cin;
    logic [3:0]  flags;
  } rsp_t;

  typedef struct packed {
    op_t         o;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_exec;
    logic        exp_we;
    logic        exp_cin;
    logic [3:0]  exp_flags;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_flags;
  logic       m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] addc(input logic [31:0] x, input logic [31:0] y,
                                       input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  // Returns {N,Z,C,V,result} as an ARM data-processing ALU would.
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [31:0] x, y, r;
    logic        arith, c, v;
    arith = 1'b1;
    x = a;
    y = b;
    s = '0;
    r = '0;
    case (op)
      4'h2, 4'hA: begin y = ~b; s = addc(a, ~b, 1'b1); end
      4'h3:       begin x = b; y = ~a; s = addc(b, ~a, 1'b1); end
      4'h4, 4'hB: s = addc(a, b, 1'b0);
      4'h5:       s = addc(a, b, cin);
      4'h6:       begin y = ~b; s = addc(a, ~b, cin); end
      4'h7:       begin x = b; y = ~a; s = addc(b, ~a, cin); end
      default:    arith = 1'b0;
    endcase
    if (arith) begin
      r = s[31:0];
      c = s[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      case (op)
        4'h0, 4'h8: r = a & b;
        4'h1, 4'h9: r = a ^ b;
        4'hC:       r = a | b;
        4'hD:       r = b;
        4'hE:       r = a & ~b;
        default:    r = ~b;
      endcase
      c = cin;
      v = 1'b0;
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    {alu_n, alu_z, alu_c, alu_v, alu_out} = alu_f(alu_if, alu_il, alu_ir, alu_cin);
  end

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.op   = 4'($urandom_range(0, 15));
    o.cond = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
    o.s    = 1'($urandom_range(0, 1));
    o.a    = rnd_word();
    o.b    = rnd_word();
    return o;
  endfunction

  task automatic drive_fields(input op_t o0, input op_t o1);
    req_op   = {o1.op, o0.op};
    req_cond = {o1.cond, o0.cond};
    req_s    = {o1.s, o0.s};
    req_a    = {o1.a, o0.a};
    req_b    = {o1.b, o0.b};
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_flags", {60'd0, flags}, 64'd0);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    rst_n   = 1'b1;
    m_flags = 4'b0000;
    m_last  = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic do_op(input logic [1:0] vmask, input op_t o0, input op_t o1,
                       input logic exp_gid, input int stall, input string tag,
                       output rsp_t r);
    op_t o;
    int  n;
    o = exp_gid ? o1 : o0;
    r = '0;
    drive_fields(o0, o1);
    req_valid = vmask;
    rsp_ready = 1'b0;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready == 2'b00) begin
      chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
      req_valid = 2'b00;
      @(negedge clk);
      return;
    end
    chk({tag, "_grant"}, {62'd0, req_ready}, exp_gid ? 64'd2 : 64'd1);
    @(posedge clk);
    #1;
    chk({tag, "_exec_ready"}, {62'd0, req_ready}, 64'd0);
    chk({tag, "_exec_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_alu_il"}, {32'd0, alu_il}, {32'd0, o.a});
    chk({tag, "_alu_ir"}, {32'd0, alu_ir}, {32'd0, o.b});
    chk({tag, "_alu_if"}, {60'd0, alu_if}, {60'd0, o.op});
    r.cin = alu_cin;
    @(posedge clk);
    #1;
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
    r.data  = rsp_data;
    r.exec  = rsp_exec;
    r.we    = rsp_we;
    r.id    = rsp_id;
    r.flags = flags;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, "_hold_ready"}, {62'd0, req_ready}, 64'd0);
      chk({tag, "_hold_data"}, {32'd0, rsp_data}, {32'd0, r.data});
      chk({tag, "_hold_id"}, {63'd0, rsp_id}, {63'd0, r.id});
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_drained"}, {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    op_t  o0, o1, o;
    rsp_t r;
    logic [1:0]  vmask;
    logic        gid, pass, cmp;
    logic [35:0] res;
    int          gr[4];
    int          gcyc[4];
    int          g;

    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_cond  = '0;
    req_s     = '0;
    req_a     = '0;
    req_b     = '0;

    //          op    cond  s  a             b             stall data          ex we cin flags
    vecs[0] = '{'{4'h4, 4'hE, 1'b1, 32'h1,        32'h1}, 0, 32'h2, 1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[1] = '{'{4'hA, 4'hE, 1'b0, 32'h5,        32'h5}, 0, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0110};
    vecs[2] = '{'{4'hD, 4'h0, 1'b0, 32'h0,        32'h7}, 5, 32'h7, 1'b1, 1'b1, 1'b1, 4'b0110};
    vecs[3] = '{'{4'hD, 4'h1, 1'b0, 32'h0,        32'h7}, 0, 32'h7, 1'b0, 1'b0, 1'b1, 4'b0110};
    vecs[4] = '{'{4'h4, 4'hE, 1'b1, 32'hFFFFFFFF, 32'h1}, 0, 32'h0, 1'b1, 1'b1, 1'b1, 4'b0110};
    vecs[5] = '{'{4'h5, 4'hE, 1'b0, 32'h1,        32'h1}, 0, 32'h3, 1'b1, 1'b1, 1'b1, 4'b0110};
    vecs[6] = '{'{4'h4, 4'hF, 1'b1, 32'h1,        32'h1}, 0, 32'h2, 1'b0, 1'b0, 1'b1, 4'b0110};

    apply_reset();

    o1 = '0;
    for (int i = 0; i < 7; i++) begin
      do_op(2'b01, vecs[i].o, o1, 1'b0, vecs[i].stall, $sformatf("vec%0d", i), r);
      chk($sformatf("vec%0d_data", i), {32'd0, r.data}, {32'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_exec", i), {63'd0, r.exec}, {63'd0, vecs[i].exp_exec});
      chk($sformatf("vec%0d_we", i), {63'd0, r.we}, {63'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_id", i), {63'd0, r.id}, 64'd0);
      chk($sformatf("vec%0d_cin", i), {63'd0, r.cin}, {63'd0, vecs[i].exp_cin});
      chk($sformatf("vec%0d_flags", i), {60'd0, r.flags}, {60'd0, vecs[i].exp_flags});
    end
    m_flags = 4'b0110;
    m_last  = 1'b0;

    // Randomized ops against the transaction-level reference.
    for (int i = 0; i < 150; i++) begin
      vmask = 2'($urandom_range(1, 3));
      o0    = rnd_op();
      o1    = rnd_op();
      gid   = (vmask == 2'b01) ? 1'b0 : (vmask == 2'b10) ? 1'b1 : ~m_last;
      o     = gid ? o1 : o0;
      do_op(vmask, o0, o1, gid, $urandom_range(0, 2), $sformatf("rnd%0d", i), r);
      pass = cond_pass(o.cond, m_flags);
      res  = alu_f(o.op, o.a, o.b, m_flags[1]);
      cmp  = (o.op[3:2] == 2'b10);
      chk("rnd_cin", {63'd0, r.cin}, {63'd0, m_flags[1]});
      if (pass && (o.s || cmp)) m_flags = res[35:32];
      m_last = gid;
      chk("rnd_data", {32'd0, r.data}, {32'd0, res[31:0]});
      chk("rnd_exec", {63'd0, r.exec}, {63'd0, pass});
      chk("rnd_we", {63'd0, r.we}, {63'd0, pass && !cmp});
      chk("rnd_id", {63'd0, r.id}, {63'd0, gid});
      chk("rnd_flags", {60'd0, r.flags}, {60'd0, m_flags});
    end

    // Reset during EXEC: everything clears at once, no stale response, FIRST_PRIO wins.
    o0 = '{4'h4, 4'hE, 1'b1, 32'h1234_5678, 32'h8765_4321};
    o1 = '{4'hC, 4'hE, 1'b1, 32'hA5A5_A5A5, 32'h0F0F_0F0F};
    drive_fields(o0, o1);
    req_valid = 2'b01;
    #1;
    chk("rstx_accept", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk("rstx_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rstx_alu", {alu_il, alu_ir}, 64'd0);
    chk("rstx_alu_if_cin", {59'd0, alu_if, alu_cin}, 64'd0);
    chk("rstx_rsp", {29'd0, rsp_valid, rsp_id, rsp_exec, rsp_we, rsp_data}, 64'd0);
    chk("rstx_flags", {60'd0, flags}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstx_first_prio", {62'd0, req_ready}, 64'd1);
    chk("rstx_no_rsp", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("rstx_no_rsp_exec", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("rstx_new_rsp", {63'd0, rsp_valid}, 64'd1);
    chk("rstx_new_data", {32'd0, rsp_data}, 64'h9999_9999);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous contention from reset with RSP_READY=1: strict alternation every 3 cycles.
    apply_reset();
    o0 = '{4'hC, 4'hE, 1'b0, 32'h1, 32'h2};
    o1 = '{4'hC, 4'hE, 1'b0, 32'h4, 32'h8};
    drive_fields(o0, o1);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    g = 0;
    #1;
    for (int c = 0; c < 40 && g < 4; c++) begin
      chk("arb_never_11", {62'd0, req_ready}, (req_ready == 2'b11) ? 64'd0 : {62'd0, req_ready});
      if (req_ready != 2'b00) begin
        gr[g]   = req_ready[1] ? 1 : 0;
        gcyc[g] = c;
        g++;
      end
      @(negedge clk);
      #1;
    end
    chk("arb_grant_count", 64'(g), 64'd4);
    for (int k = 0; k < g; k++) begin
      chk($sformatf("arb_order%0d", k), 64'(gr[k]), 64'(k % 2));
      if (k > 0) chk($sformatf("arb_gap%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd3);
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("arb_flags", {60'd0, flags}, 64'd0);
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
